// File: rtl/inst_fetch_port.sv
// inst_fetch_port: instruction-side responder for the pipelined RV32I core.
// Serves the fetch address from a one-entry buffer and turns each miss into
// a request/grant/response transaction on the instruction-memory bus.
// Responses are dropped when a redirect or flush makes them stale.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   pc_i, flush_i               fetch address, buffer/fetch invalidate
//   inst_o, inst_valid_o        instruction to IF/ID (NOP when not valid)
//   stall_o, fetch_fault_o      bubble request, sticky fault
//   mem_req_o, mem_addr_o       bus request and word-aligned address
//   mem_gnt_i                   request accepted
//   mem_rvalid_i, mem_rdata_i   response valid and data
//   mem_err_i                   response error (qualified by rvalid)
module inst_fetch_port #(
    parameter logic [31:0] NOP     = 32'h0000_0013,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_o,
    output logic        fetch_fault_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned WORD_W = 30;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   buf_addr_q, buf_addr_d;
    logic [31:0]         buf_data_q, buf_data_d;
    logic                buf_vld_q, buf_vld_d;
    logic [WORD_W-1:0]   req_addr_q, req_addr_d;
    logic                discard_q, discard_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fault_q, fault_d;

    logic [WORD_W-1:0]   pc_word;
    logic                aligned_c;
    logic                hit_c;
    logic                stale_c;
    logic                valid_c;
    logic                req_c;
    logic [31:0]         addr_c;

    assign pc_word   = pc_i[31:2];
    assign aligned_c = (pc_i[1:0] == 2'b00);
    assign hit_c     = buf_vld_q && (pc_word == buf_addr_q) && !flush_i;
    // The outstanding fetch no longer matches what the core wants.
    assign stale_c   = (pc_word != req_addr_q) || flush_i;
    assign valid_c   = (state_q == S_IDLE) && hit_c && aligned_c;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_vld_q  <= 1'b0;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_vld_q  <= buf_vld_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state and bus request logic
    always_comb begin
        state_d    = state_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_vld_d  = buf_vld_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        req_c      = 1'b0;
        addr_c     = 32'h0;

        unique case (state_q)
            S_IDLE: begin
                discard_d = 1'b0;
                cnt_d     = '0;
                if (!hit_c && aligned_c && !fault_q) begin
                    req_c      = 1'b1;
                    addr_c     = {pc_word, 2'b00};
                    req_addr_d = pc_word;
                    state_d    = mem_gnt_i ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // Address stays pinned to the latched request until granted.
                req_c  = 1'b1;
                addr_c = {req_addr_q, 2'b00};
                if (stale_c) discard_d = 1'b1;
                if (mem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (stale_c) discard_d = 1'b1;
                if (mem_rvalid_i) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    if (mem_err_i) begin
                        fault_d   = 1'b1;
                        buf_vld_d = 1'b0;
                    end else if (!(discard_q || stale_c)) begin
                        buf_addr_d = req_addr_q;
                        buf_data_d = mem_rdata_i;
                        buf_vld_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    fault_d   = 1'b1;
                    buf_vld_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!aligned_c) fault_d = 1'b1;
        // Flush wins over any same-cycle buffer write.
        if (flush_i) buf_vld_d = 1'b0;
    end

    // Outputs are forced to their idle values while reset is held.
    assign inst_valid_o  = rst_ni && valid_c;
    assign inst_o        = inst_valid_o ? buf_data_q : NOP;
    assign stall_o       = rst_ni && !valid_c && aligned_c && !fault_q;
    assign fetch_fault_o = fault_q;
    assign mem_req_o     = rst_ni && req_c;
    assign mem_addr_o    = rst_ni ? addr_c : 32'h0;

endmodule

// File: doc/inst_fetch_port.md
# inst_fetch_port

Instruction-side responder for the pipelined RV32I core. Takes the fetch address `pc` driven by the control unit and returns the 32-bit instruction that feeds the IF/ID pipeline register. Translates each miss into a request/grant/response transaction on a variable-latency instruction-memory bus. Holds a one-entry fetch buffer, inserts NOP bubbles with `stall` while a fetch is outstanding, and discards responses made stale by a branch redirect or flush.

## Interface
Parameters:
- `NOP`, 32'h00000013, instruction (addi x0,x0,0) driven on `inst` whenever `inst_valid`=0
- `TIMEOUT`, 255, maximum WAIT cycles before a fetch fault; counter width $clog2(TIMEOUT+1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `pc`  in  32  fetch address from the control unit
- `flush`  in  1  invalidate buffer / cancel outstanding fetch (fence.i, exception)
- `inst`  out  32  instruction to IF/ID register
- `inst_valid`  out  1  `inst` is the word at `pc`
- `stall`  out  1  control unit must hold `pc` and insert bubble
- `fetch_fault`  out  1  sticky: misaligned pc, bus error or timeout
- `mem_req`  out  1  bus request
- `mem_addr`  out  32  word-aligned bus address
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  response data valid
- `mem_rdata`  in  32  response data
- `mem_err`  in  1  response error, qualified by `mem_rvalid`

## Operation
- Buffer: `buf_addr[31:2]`, `buf_data`, `buf_vld`. Hit = `buf_vld` && `pc[31:2]`==`buf_addr` && !`flush`.
- Misaligned: `pc[1:0]`!=0 → no request, `inst`=NOP, `inst_valid`=0, `stall`=0, `fetch_fault` set next edge.
- FSM states IDLE, REQ, WAIT:
  - IDLE, hit: `inst`=`buf_data`, `inst_valid`=1, `stall`=0.
  - IDLE, miss (aligned, no fault): `mem_req`=1, `mem_addr`={pc[31:2],2'b00}, latch `req_addr`. gnt → WAIT, else → REQ.
  - REQ: `mem_req`=1, `mem_addr`=`req_addr` held stable regardless of `pc`. On gnt → WAIT.
  - WAIT: `mem_req`=0. Timeout counter increments each cycle.
    - `mem_rvalid` with `mem_err`=0 and no discard: write buffer (`buf_addr`=`req_addr`, `buf_vld`=1), → IDLE.
    - `mem_rvalid` with discard: drop data, `buf_vld` unchanged, → IDLE.
    - `mem_err`=1 or counter==TIMEOUT: `fetch_fault`=1, `buf_vld`=0, → IDLE.
- Discard flag: set in REQ/WAIT when `pc[31:2]`!=`req_addr` or `flush`=1. Cleared on entry to IDLE.
- `flush` in any state clears `buf_vld` at the next edge. A request already asserted still completes its handshake; it is never withdrawn.
- `stall` = !`inst_valid` && `pc` aligned && !`fetch_fault`.
- `inst`=NOP whenever `inst_valid`=0.
- Fault behaviour: `fetch_fault` sticky until reset. While set, no new requests issue; an in-flight WAIT still drains its response.

## Timing
- Reset (rst=0, async): state IDLE, `buf_vld`=0, discard=0, counter=0, `fetch_fault`=0, `mem_req`=0, `mem_addr`=0, `inst`=NOP, `inst_valid`=0, `stall`=0 (outputs forced while in reset).
- Reset mid-transaction abandons it. A later stray `mem_rvalid` in IDLE is ignored.
- Hit: combinational, zero stall.
- Miss penalty: 1 + grant wait + response wait.
  - Best case (gnt in request cycle, rvalid next cycle): stall in cycles 0–1, `inst_valid` in cycle 2.
- Back-to-back misses: the new request may issue in the IDLE cycle right after the response.
- `mem_rvalid` outside WAIT is ignored.
- `mem_gnt` outside a `mem_req` cycle is ignored.

## Test plan
- Reset then `pc`=0x0, gnt same cycle, rvalid next cycle with rdata=0x00500093 → `stall`=1 for 2 cycles; cycle 2 `inst`=0x00500093, `inst_valid`=1; `mem_req` high only in cycle 0.
- Hit: same `pc` again → `inst` from buffer, `mem_req`=0, `stall`=0.
- Grant delayed 3 cycles at `pc`=0x40, with `pc` changed to 0x80 during REQ → `mem_addr` stays 0x40 until gnt. Response discarded. A new request for 0x80 issues in the next IDLE cycle.
- `flush` during WAIT for 0x10 → rdata dropped, `buf_vld`=0. Refetch of 0x10 issues.
- No rvalid for TIMEOUT cycles → `fetch_fault`=1, `stall`=0, `inst`=NOP. No further `mem_req` until reset.
- `pc`=0x6 → `fetch_fault`=1 next cycle, `mem_req` never asserted.
- Response with `mem_err`=1 → `fetch_fault`=1, `buf_vld`=0.
